exc_ctrl: RTL and testbench

- Exception control unit sitting directly downstream of the main decoder.
- Consumes the decoder's NotAnInstr/EStatus/ERet outputs and an external interrupt line.
- Owns the system registers ELR (return PC), ESR (cause code) and ESync (synchronous flag), and drives the PC redirect for exception entry and ERET.
- Sources the read data for MRS.

---
 rtl/exc_pkg.sv | 9 +
 rtl/sysreg_file.sv | 37 +++
 rtl/exc_ctrl.sv | 62 ++++++
 tb/tb_exc_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// exc_pkg: shared state, cause-code and MRS selector definitions for the exception unit
package exc_pkg;
    typedef enum logic [1:0] {RUN, HANDLER, FAULT} exc_state_t;
    localparam logic [3:0] ESR_EXTIRQ = 4'b0001;
    localparam logic [3:0] ESR_BADOP  = 4'b0010;
    localparam logic [1:0] MRS_ELR    = 2'b00;
    localparam logic [1:0] MRS_ESR    = 2'b01;
    localparam logic [1:0] MRS_ESYNC  = 2'b10;
endpackage

// File: rtl/sysreg_file.sv
// sysreg_file: ELR/ESR/ESync system registers and the MRS read mux
module sysreg_file import exc_pkg::*; #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we,
    input  logic [N-1:0] elr_in,
    input  logic [3:0]   esr_in,
    input  logic         esync_in,
    input  logic [1:0]   sel,
    output logic [N-1:0] elr,
    output logic [3:0]   esr,
    output logic [N-1:0] mrs_data
);
    logic esync;

    // Capture the exception context on entry; values persist across ERET
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            elr   <= '0;
            esr   <= '0;
            esync <= 1'b0;
        end else if (we) begin
            elr   <= elr_in;
            esr   <= esr_in;
            esync <= esync_in;
        end
    end

    // MRS read path, zero-extended to the datapath width
    always_comb begin
        mrs_data = sel == MRS_ELR   ? elr :
                   sel == MRS_ESR   ? {{(N-4){1'b0}}, esr} :
                   sel == MRS_ESYNC ? {{(N-1){1'b0}}, esync} : '0;
    end
endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/interrupt entry, ERET return and double-fault halt
module exc_ctrl import exc_pkg::*; #(
    parameter int N = 64,
    parameter logic [N-1:0] VECTOR_ADDR = N'(64'h0000_0000_0000_00D8)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         Stall,
    input  logic [N-1:0] PC_D,
    input  logic         NotAnInstr,
    input  logic [3:0]   EStatus,
    input  logic         ERet,
    input  logic         ExtIRQ,
    input  logic [1:0]   MrsSel,
    output logic         ExtIAck,
    output logic         Exc,
    output logic [N-1:0] ExcVector,
    output logic         ERetTaken,
    output logic [N-1:0] ERetPC,
    output logic         InHandler,
    output logic         Halt,
    output logic [N-1:0] MrsData,
    output logic [N-1:0] ELR,
    output logic [3:0]   ESR
);
    exc_state_t state;
    logic live, take_bad, take_irq, dbl;

    // Pulses are suppressed while stalled or held in reset
    assign live      = reset && !Stall;
    assign take_bad  = live && state == RUN && NotAnInstr;
    assign take_irq  = live && state == RUN && !NotAnInstr && ExtIRQ;
    assign dbl       = live && state == HANDLER && NotAnInstr;
    assign Exc       = take_bad || take_irq;
    assign ExtIAck   = take_irq;
    assign ERetTaken = live && state == HANDLER && ERet && !NotAnInstr;
    assign ExcVector = VECTOR_ADDR;
    assign ERetPC    = ELR;
    assign InHandler = state == HANDLER;
    assign Halt      = state == FAULT;

    // Exception FSM; FAULT is left only through reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         state <= RUN;
        else if (Exc)       state <= HANDLER;
        else if (ERetTaken) state <= RUN;
        else if (dbl)       state <= FAULT;
    end

    sysreg_file #(.N(N)) u_sysreg (
        .clk      (clk),
        .reset    (reset),
        .we       (Exc),
        .elr_in   (PC_D),
        .esr_in   (take_bad ? EStatus : ESR_EXTIRQ),
        .esync_in (take_bad),
        .sel      (MrsSel),
        .elr      (ELR),
        .esr      (ESR),
        .mrs_data (MrsData)
    );
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed and randomized checks of exc_ctrl against a behavioural model
module tb_exc_ctrl;
    logic        clk = 0;
    logic        reset = 0;
    logic        Stall = 0;
    logic [63:0] PC_D = '0;
    logic        NotAnInstr = 0;
    logic [3:0]  EStatus = '0;
    logic        ERet = 0;
    logic        ExtIRQ = 0;
    logic [1:0]  MrsSel = '0;
    logic        ExtIAck, Exc, ERetTaken, InHandler, Halt;
    logic [63:0] ExcVector, ERetPC, MrsData, ELR;
    logic [3:0]  ESR;

    int vectors = 0;
    int miscompares = 0;

    exc_ctrl dut (
        .clk(clk), .reset(reset), .Stall(Stall), .PC_D(PC_D), .NotAnInstr(NotAnInstr),
        .EStatus(EStatus), .ERet(ERet), .ExtIRQ(ExtIRQ), .MrsSel(MrsSel),
        .ExtIAck(ExtIAck), .Exc(Exc), .ExcVector(ExcVector), .ERetTaken(ERetTaken),
        .ERetPC(ERetPC), .InHandler(InHandler), .Halt(Halt), .MrsData(MrsData),
        .ELR(ELR), .ESR(ESR)
    );

    always #5 clk = ~clk;

    // Model: mode 0 = running, 1 = in handler, 2 = halted
    int          m_mode = 0;
    logic [63:0] m_elr = '0;
    logic [3:0]  m_esr = '0;
    logic        m_esync = 0;

    // Event the current cycle represents: 0 none, 1 bad opcode, 2 interrupt, 3 eret, 4 double fault
    function automatic int event_now();
        if (!reset || Stall) return 0;
        if (m_mode == 0) return NotAnInstr ? 1 : (ExtIRQ ? 2 : 0);
        if (m_mode == 1) return NotAnInstr ? 4 : (ERet ? 3 : 0);
        return 0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode <= 0;
            m_elr <= '0;
            m_esr <= '0;
            m_esync <= 0;
        end else begin
            case (event_now())
                1: begin m_mode <= 1; m_elr <= PC_D; m_esr <= EStatus; m_esync <= 1; end
                2: begin m_mode <= 1; m_elr <= PC_D; m_esr <= 4'd1; m_esync <= 0; end
                3: m_mode <= 0;
                4: m_mode <= 2;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        int ev;
        logic [63:0] mrs;
        ev = event_now();
        mrs = MrsSel == 2'd0 ? m_elr : MrsSel == 2'd1 ? {60'd0, m_esr} :
              MrsSel == 2'd2 ? {63'd0, m_esync} : 64'd0;
        chk("m_Exc", Exc, (ev == 1 || ev == 2) ? 64'd1 : 64'd0);
        chk("m_ExtIAck", ExtIAck, ev == 2 ? 64'd1 : 64'd0);
        chk("m_ERetTaken", ERetTaken, ev == 3 ? 64'd1 : 64'd0);
        chk("m_ERetPC", ERetPC, m_elr);
        chk("m_InHandler", InHandler, m_mode == 1 ? 64'd1 : 64'd0);
        chk("m_Halt", Halt, m_mode == 2 ? 64'd1 : 64'd0);
        chk("m_ELR", ELR, m_elr);
        chk("m_ESR", ESR, m_esr);
        chk("m_MrsData", MrsData, mrs);
        chk("m_ExcVector", ExcVector, 64'hD8);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        NotAnInstr = 0; ExtIRQ = 0; ERet = 0; Stall = 0; EStatus = '0; MrsSel = '0;
    endtask

    initial begin
        // Reset with arbitrary inputs
        NotAnInstr = 1; ExtIRQ = 1; ERet = 1; PC_D = 64'h123; EStatus = 4'hF;
        tick();
        tick();
        chk("rst_Exc", Exc, 0); chk("rst_ExtIAck", ExtIAck, 0); chk("rst_ERetTaken", ERetTaken, 0);
        chk("rst_InHandler", InHandler, 0); chk("rst_Halt", Halt, 0);
        for (int s = 0; s < 4; s++) begin
            MrsSel = 2'(s);
            #1 chk("rst_MrsData", MrsData, 0);
        end
        idle();
        reset = 1;
        tick();
        chk("idle_Exc", Exc, 0); chk("idle_InHandler", InHandler, 0);
        // Bad opcode entry and return
        PC_D = 64'h40; NotAnInstr = 1; EStatus = 4'b0010;
        #1 chk("bad_Exc", Exc, 1);
        chk("vector", ExcVector, 64'hD8);
        tick(); idle();
        MrsSel = 2'b10;
        #1 chk("bad_ELR", ELR, 64'h40); chk("bad_ESR", ESR, 2); chk("bad_InHandler", InHandler, 1);
        chk("bad_ESync", MrsData, 1);
        ERet = 1;
        #1 chk("eret_Taken", ERetTaken, 1); chk("eret_PC", ERetPC, 64'h40); chk("eret_Exc", Exc, 0);
        tick(); idle();
        chk("eret_InHandler", InHandler, 0);
        // Interrupt entry, masked while in handler
        PC_D = 64'h80; ExtIRQ = 1;
        #1 chk("irq_Exc", Exc, 1); chk("irq_Ack", ExtIAck, 1);
        tick();
        MrsSel = 2'b10;
        #1 chk("irq_ESR", ESR, 1); chk("irq_ELR", ELR, 64'h80); chk("irq_ESync", MrsData, 0);
        for (int i = 0; i < 5; i++) begin
            chk("mask_Exc", Exc, 0); chk("mask_Ack", ExtIAck, 0);
            tick();
        end
        ExtIRQ = 0; ERet = 1;
        tick(); idle();
        // Simultaneous bad opcode and interrupt
        PC_D = 64'h10; NotAnInstr = 1; ExtIRQ = 1; EStatus = 4'b0010;
        #1 chk("sim_Exc", Exc, 1); chk("sim_Ack", ExtIAck, 0);
        tick(); NotAnInstr = 0;
        #1 chk("sim_ESR", ESR, 2);
        ERet = 1;
        #1 chk("sim_eret", ERetTaken, 1); chk("sim_noexc", Exc, 0);
        tick(); ERet = 0;
        #1 chk("pend_Exc", Exc, 1); chk("pend_Ack", ExtIAck, 1);
        tick(); ExtIRQ = 0;
        #1 chk("pend_ESR", ESR, 1); chk("pend_ELR", ELR, 64'h10);
        // Double fault
        PC_D = 64'h999; NotAnInstr = 1;
        #1 chk("df_Exc", Exc, 0);
        tick(); idle();
        chk("df_Halt", Halt, 1); chk("df_ELR", ELR, 64'h10);
        NotAnInstr = 1; ERet = 1; ExtIRQ = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("df_sticky", Halt, 1); chk("df_quiet", Exc | ExtIAck | ERetTaken, 0);
        end
        reset = 0;
        #1 chk("df_clear", Halt, 0);
        tick(); idle(); reset = 1;
        tick();
        // Stall holds off entry
        Stall = 1; NotAnInstr = 1; PC_D = 64'h200; EStatus = 4'd5;
        #1 chk("stall_Exc", Exc, 0);
        tick();
        chk("stall_ELR", ELR, 0); chk("stall_InHandler", InHandler, 0);
        Stall = 0;
        #1 chk("unstall_Exc", Exc, 1);
        tick(); idle();
        chk("unstall_ELR", ELR, 64'h200); chk("unstall_ESR", ESR, 5);
        ERet = 1;
        tick(); idle();
        // ERET outside handler is a NOP
        ERet = 1;
        #1 chk("nop_eret", ERetTaken, 0);
        tick(); idle();
        chk("nop_state", InHandler, 0);
        // Reset mid-handler clears state asynchronously
        NotAnInstr = 1; PC_D = 64'h300;
        tick(); idle();
        chk("mid_In", InHandler, 1);
        #1 reset = 0;
        #1 chk("mid_InHandler", InHandler, 0); chk("mid_ELR", ELR, 0);
        tick(); reset = 1;
        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (!reset) reset = 1;
            else if ($urandom_range(0, 99) == 0) reset = 0;
            NotAnInstr = $urandom_range(0, 7) == 0;
            ExtIRQ = $urandom_range(0, 3) == 0;
            ERet = $urandom_range(0, 2) == 0;
            Stall = $urandom_range(0, 5) == 0;
            PC_D = {$urandom, $urandom};
            EStatus = 4'($urandom);
            MrsSel = 2'($urandom);
        end
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
